// File: rtl/branch_target_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : branch_target_buffer                                          |
// | Brief    : Direct-mapped BTB with 2-bit saturating direction counters;   |
// |            BTB_STATS_EN adds update/mispredict event counters.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module branch_target_buffer #(
  parameter int         ENTRIES  = 16,
  parameter int         PC_W     = 32,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [PC_W-1:0] lookup_pc,
  output logic [PC_W-1:0] pred_npc,
  output logic            pred_taken,
  output logic            pred_hit,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            upd_mispredict,
  input  logic            flush_all,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts
);

  localparam int              c_IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int              c_TAG_W   = PC_W - c_IDX_W - 2;
  localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);

  generate
    if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
      $error("branch_target_buffer: ENTRIES must be a power of two >= 2");
    end
  endgenerate

  logic [ENTRIES-1:0] r_valid;
  logic [c_TAG_W-1:0] r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];

  logic [c_IDX_W-1:0] w_lk_idx;
  logic [c_IDX_W-1:0] w_up_idx;
  logic [c_TAG_W-1:0] w_lk_tag;
  logic [c_TAG_W-1:0] w_up_tag;
  logic               w_up_hit;
  logic               w_up_write;
  logic [1:0]         w_up_cnt;
  logic               w_unused_bits;

  assign w_lk_idx = lookup_pc[c_IDX_W+1:2];
  assign w_lk_tag = lookup_pc[PC_W-1:c_IDX_W+2];
  assign w_up_idx = upd_pc[c_IDX_W+1:2];
  assign w_up_tag = upd_pc[PC_W-1:c_IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle update is never bypassed.
  assign pred_hit   = r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
  assign pred_taken = pred_hit & r_cnt[w_lk_idx][1];
  assign pred_npc   = pred_taken ? r_target[w_lk_idx] : lookup_pc + c_PC_STEP;

  assign w_up_hit   = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);
  assign w_up_write = upd_en & ~flush_all & (w_up_hit | upd_taken);

  always_comb begin
    w_up_cnt = r_cnt[w_up_idx];
    if (w_up_hit) begin
      if (upd_taken) begin
        if (w_up_cnt != 2'b11) w_up_cnt = w_up_cnt + 2'd1;
      end else begin
        if (w_up_cnt != 2'b00) w_up_cnt = w_up_cnt - 2'd1;
      end
    end else begin
      w_up_cnt = CNT_INIT;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= 2'b01;
    end else if (flush_all) begin
      r_valid <= '0;
    end else if (w_up_write) begin
      r_valid[w_up_idx] <= 1'b1;
      r_cnt[w_up_idx]   <= w_up_cnt;
    end
  end

  // Tag and target need no reset: they are only read behind a valid bit.
  always_ff @(posedge CLK) begin
    if (w_up_write && upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_mispredicts;

  // Counted independently of flush_all so dropped updates still show up.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_lookups     <= '0;
      r_stat_mispredicts <= '0;
    end else if (upd_en) begin
      r_stat_lookups <= r_stat_lookups + 32'd1;
      if (upd_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_lookups     = r_stat_lookups;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_lookups     = 32'h0;
  assign stat_mispredicts = 32'h0;
`endif

  assign w_unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_mispredict};

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_branch_target_buffer                                       |
// | Brief    : Self-checking bench for branch_target_buffer (BTB_STATS_EN    |
// |            aware) against a slot-array reference model.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int PC_W    = 32;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lookup_pc, upd_pc, upd_target;
  logic        upd_en, upd_taken, upd_mispredict, flush_all;
  logic [31:0] pred_npc, stat_lookups, stat_mispredicts;
  logic        pred_taken, pred_hit;

  branch_target_buffer #(.ENTRIES(ENTRIES), .PC_W(PC_W), .CNT_INIT(2'b10)) dut (
    .CLK(CLK), .nRST(nRST),
    .lookup_pc(lookup_pc), .pred_npc(pred_npc), .pred_taken(pred_taken), .pred_hit(pred_hit),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_mispredict(upd_mispredict), .flush_all(flush_all),
    .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each slot remembers the word address (pc>>2) it was allocated for.
  bit          m_valid [ENTRIES];
  logic [31:0] m_line  [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_lookups, m_misp;
  int          ms, cs;
  bit          e_hit, e_tk;
  logic [31:0] e_npc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 1;
      end
      m_lookups = 0;
      m_misp    = 0;
    end else begin
      if (upd_en) begin
        m_lookups = m_lookups + 1;
        if (upd_mispredict) m_misp = m_misp + 1;
      end
      if (flush_all) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (upd_en) begin
        ms = slot(upd_pc);
        if (m_valid[ms] && m_line[ms] == (upd_pc >> 2)) begin
          if (upd_taken) begin
            m_cnt[ms] = (m_cnt[ms] < 3) ? m_cnt[ms] + 1 : 3;
            m_tgt[ms] = upd_target;
          end else begin
            m_cnt[ms] = (m_cnt[ms] > 0) ? m_cnt[ms] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[ms] = 1'b1;
          m_line[ms]  = upd_pc >> 2;
          m_tgt[ms]   = upd_target;
          m_cnt[ms]   = 2;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      cs    = slot(lookup_pc);
      e_hit = m_valid[cs] && (m_line[cs] == (lookup_pc >> 2));
      e_tk  = e_hit && (m_cnt[cs] >= 2);
      e_npc = e_tk ? m_tgt[cs] : lookup_pc + 32'd4;
      chk("model_hit", 32'(pred_hit), 32'(e_hit));
      chk("model_taken", 32'(pred_taken), 32'(e_tk));
      chk("model_npc", pred_npc, e_npc);
`ifdef BTB_STATS_EN
      chk("model_stat_lookups", stat_lookups, m_lookups);
      chk("model_stat_misp", stat_mispredicts, m_misp);
`else
      chk("stat_lookups_tied", stat_lookups, 32'h0);
      chk("stat_misp_tied", stat_mispredicts, 32'h0);
`endif
    end
  end

  task automatic cyc(input logic [31:0] lpc, input bit ue, input logic [31:0] upc,
                     input logic [31:0] utgt, input bit utk, input bit umis, input bit fl);
    @(posedge CLK);
    #1;
    lookup_pc      = lpc;
    upd_en         = ue;
    upd_pc         = upc;
    upd_target     = utgt;
    upd_taken      = utk;
    upd_mispredict = umis;
    flush_all      = fl;
    @(negedge CLK);
  endtask

  task automatic look(input logic [31:0] lpc);
    cyc(lpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string name, input bit hit, input bit tk, input logic [31:0] npc);
    chk({name, "_hit"}, 32'(pred_hit), 32'(hit));
    chk({name, "_taken"}, 32'(pred_taken), 32'(tk));
    chk({name, "_npc"}, pred_npc, npc);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(0, 7) == 0) begin
      p = $urandom;
    end else begin
      p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
    end
    return p;
  endfunction

  logic [31:0] s0;

  initial begin
    nRST = 1'b0;
    lookup_pc = 32'h40; upd_en = 0; upd_pc = 0; upd_target = 0;
    upd_taken = 0; upd_mispredict = 0; flush_all = 0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    chk_on = 1'b1;

    look(32'h0000_0040);
    expect_out("reset", 1'b0, 1'b0, 32'h0000_0044);
    chk("reset_stat_lookups", stat_lookups, 32'h0);

    cyc(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0);
    expect_out("no_bypass", 1'b0, 1'b0, 32'h44);
    look(32'h40);
    expect_out("alloc", 1'b1, 1'b1, 32'h100);

    cyc(32'h40, 1'b1, 32'h40, 32'h100, 1'b0, 1'b1, 1'b0);
    cyc(32'h40, 1'b1, 32'h40, 32'h100, 1'b0, 1'b1, 1'b0);
    expect_out("cnt01", 1'b1, 1'b0, 32'h44);
    look(32'h40);
    expect_out("cnt00", 1'b1, 1'b0, 32'h44);

    repeat (2) cyc(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0);
    expect_out("cnt01_up", 1'b1, 1'b0, 32'h44);
    cyc(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0);
    expect_out("cnt10_up", 1'b1, 1'b1, 32'h100);
    cyc(32'h40, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 1'b0);
    cyc(32'h40, 1'b1, 32'h40, 32'h100, 1'b0, 1'b0, 1'b0);
    expect_out("cnt11_sat", 1'b1, 1'b1, 32'h100);
    look(32'h40);
    expect_out("cnt10_after_sat", 1'b1, 1'b1, 32'h100);

    cyc(32'h40, 1'b1, 32'h440, 32'h200, 1'b1, 1'b0, 1'b0);
    look(32'h40);
    expect_out("alias_old", 1'b0, 1'b0, 32'h44);
    look(32'h440);
    expect_out("alias_new", 1'b1, 1'b1, 32'h200);
    look(32'h443);
    expect_out("low_bits_ignored", 1'b1, 1'b1, 32'h200);

    s0 = stat_lookups;
    cyc(32'h440, 1'b1, 32'h80, 32'h300, 1'b1, 1'b0, 1'b1);
    look(32'h440);
    expect_out("flush_old", 1'b0, 1'b0, 32'h444);
    look(32'h80);
    expect_out("flush_dropped", 1'b0, 1'b0, 32'h84);
`ifdef BTB_STATS_EN
    chk("flush_stat_counts", stat_lookups, s0 + 32'd1);
`else
    chk("flush_stat_tied", stat_lookups, 32'h0);
`endif

    look(32'hFFFF_FFFC);
    expect_out("wrap", 1'b0, 1'b0, 32'h0000_0000);

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        @(posedge CLK);
        #1;
        upd_en = 1'b0; flush_all = 1'b0;
        lookup_pc = m_line[0] << 2;
        nRST = 1'b0;
        #1;
        chk("midreset_hit", 32'(pred_hit), 32'h0);
        chk("midreset_npc", pred_npc, lookup_pc + 32'd4);
        chk("midreset_stat_lookups", stat_lookups, 32'h0);
        chk("midreset_stat_misp", stat_mispredicts, 32'h0);
        @(negedge CLK);
        @(posedge CLK);
        #1 nRST = 1'b1;
      end
      cyc(rand_pc(), 1'($urandom_range(0, 1)), rand_pc(), $urandom,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
          $urandom_range(0, 59) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
